// File: rtl/i2c_cmd_seq.sv
// i2c_cmd_seq: command FIFO plus sequencer that hands one transaction at a
// time to a downstream I2C core and holds read results for a consumer.
// Optional watchdog on the core handshake, enabled by defining the macro
// I2C_SEQ_TIMEOUT_EN; without it timeout_err is tied low.
module i2c_cmd_seq #(
  parameter int DEPTH          = 4,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   cmd_wr,
  input  logic [6:0]             cmd_addr,
  input  logic [7:0]             cmd_data,
  output logic                   newd,
  output logic                   wr,
  output logic [6:0]             addr,
  output logic [7:0]             din,
  input  logic                   done,
  input  logic [7:0]             datard,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [7:0]             rsp_data,
  output logic [6:0]             rsp_addr,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] level,
  output logic                   timeout_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  // Reject configurations the pointer arithmetic cannot support.
  if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("i2c_cmd_seq: DEPTH must be a power of 2 in 2..16");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("i2c_cmd_seq: TIMEOUT_CYCLES must be at least 2");
  end

  // FIFO entry layout: {wr, addr[6:0], data[7:0]}
  logic [15:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] count_q, count_d;
  logic [1:0]    state_q, state_d;
  logic          wr_q, wr_d;
  logic [6:0]    addr_q, addr_d;
  logic [7:0]    din_q, din_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [7:0]    rsp_data_q, rsp_data_d;
  logic [6:0]    rsp_addr_q, rsp_addr_d;
  logic          push, pop, head_ok;
  logic [15:0]   head;

`ifdef I2C_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic          tmo_err_q, tmo_err_d;
`endif

  assign cmd_ready = (count_q < LW'(DEPTH));
  assign push      = cmd_valid && cmd_ready;
  assign pop       = (state_q == ISSUE) && (count_q != '0);
  assign head      = mem_q[rd_ptr_q];
  // A read may only start when the previous read result has been taken.
  assign head_ok   = (count_q != '0) && (head[15] || !rsp_valid_q);

  // FIFO pointer and occupancy bookkeeping; the head leaves in the ISSUE cycle.
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
  end

  // FIFO storage; contents need no reset because occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {cmd_wr, cmd_addr, cmd_data};
    end
  end

  // Sequencer: launch head command, wait for core, route read data to response.
  always_comb begin
    state_d    = state_q;
    wr_d       = wr_q;
    addr_d     = addr_q;
    din_d      = din_q;
    rsp_data_d = rsp_data_q;
    rsp_addr_d = rsp_addr_q;
`ifdef I2C_SEQ_TIMEOUT_EN
    tmo_err_d  = tmo_err_q;
    tmo_cnt_d  = '0;
`endif
    case (state_q)
      IDLE: begin
        if (head_ok) begin
          state_d = ISSUE;
          wr_d    = head[15];
          addr_d  = head[14:8];
          din_d   = head[7:0];
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (done) begin
          if (wr_q) begin
            state_d = IDLE;
          end else begin
            state_d    = RESP;
            rsp_data_d = datard;
            rsp_addr_d = addr_q;
          end
        end
`ifdef I2C_SEQ_TIMEOUT_EN
        else if (tmo_cnt_q == TMO_LAST) begin
          state_d   = IDLE;
          tmo_err_d = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
`endif
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Response holding register: set on leaving RESP, cleared by the consumer.
  always_comb begin
    rsp_valid_d = rsp_valid_q;
    if (state_q == RESP) begin
      rsp_valid_d = 1'b1;
    end else if (rsp_valid_q && rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      state_q     <= IDLE;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      din_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_addr_q  <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      state_q     <= state_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      din_q       <= din_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_addr_q  <= rsp_addr_d;
    end
  end

`ifdef I2C_SEQ_TIMEOUT_EN
  // Watchdog counter and sticky error flag; only reset clears the flag.
  always_ff @(posedge clk) begin
    if (!rst) begin
      tmo_cnt_q <= '0;
      tmo_err_q <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      tmo_err_q <= tmo_err_d;
    end
  end
  assign timeout_err = tmo_err_q;
`else
  assign timeout_err = 1'b0;
`endif

  assign newd      = (state_q == ISSUE);
  assign busy      = (state_q != IDLE);
  assign wr        = wr_q;
  assign addr      = addr_q;
  assign din       = din_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_addr  = rsp_addr_q;
  assign level     = count_q;

endmodule

// File: tb/tb_i2c_cmd_seq.sv
// tb_i2c_cmd_seq: vector table, directed corner sequences and a randomized
// run against a queue-based reference model of the command sequencer.
module tb_i2c_cmd_seq;

  localparam int DEPTH = 4;
  localparam int TMO   = 16;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_wr = 1'b0;
  logic [6:0]    cmd_addr = '0;
  logic [7:0]    cmd_data = '0;
  logic          newd, wr;
  logic [6:0]    addr;
  logic [7:0]    din;
  logic          done = 1'b0;
  logic [7:0]    datard = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [7:0]    rsp_data;
  logic [6:0]    rsp_addr;
  logic          busy;
  logic [LW-1:0] level;
  logic          timeout_err;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic       wr;
    logic [6:0] addr;
    logic [7:0] data;
    logic [7:0] rd;
    logic       exp_rsp;
    logic [7:0] exp_rsp_data;
  } vec_t;

  typedef struct {
    logic       wr;
    logic [6:0] addr;
    logic [7:0] data;
  } cmd_t;

  vec_t vecs[5];
  cmd_t mq[$];
  cmd_t cur;
  logic inflight, resp_phase, exp_rv, pop_pending, in_wait, pre_idle, will_issue, accepted;
  logic [7:0] exp_rd;
  logic [6:0] exp_ra;
  int since, delay;
  logic [6:0] got_a;
  logic got_w;
  logic [7:0] got_d;
  logic seen;
  logic [6:0] order_exp[5];

  i2c_cmd_seq #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .newd(newd), .wr(wr), .addr(addr), .din(din),
    .done(done), .datard(datard),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_addr(rsp_addr),
    .busy(busy), .level(level), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic w, input logic [6:0] a, input logic [7:0] d);
    cmd_valid = v;
    cmd_wr    = w;
    cmd_addr  = a;
    cmd_data  = d;
  endtask

  task automatic doReset();
    applyStimulus(1'b0, 1'b0, 7'h0, 8'h0);
    done = 1'b0;
    rsp_ready = 1'b0;
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic waitNewd(input string name, output logic [6:0] a, output logic w, output logic [7:0] d);
    int n = 0;
    while (!newd && n < 64) begin
      tick();
      n++;
    end
    if (!newd) checkOutput({name, " newd wait expired"}, 32'd0, 32'd1);
    a = addr;
    w = wr;
    d = din;
  endtask

  // Called in the newd cycle: step into WAIT, then pulse done for one cycle.
  task automatic finishTxn(input logic [7:0] rd);
    tick();
    done = 1'b1;
    datard = rd;
    tick();
    done = 1'b0;
    datard = 8'hEE;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vecs[0] = '{1'b1, 7'h12, 8'hA5, 8'h00, 1'b0, 8'h00};
    vecs[1] = '{1'b0, 7'h12, 8'h00, 8'h5A, 1'b1, 8'h5A};
    vecs[2] = '{1'b1, 7'h7F, 8'hFF, 8'h3C, 1'b0, 8'h00};
    vecs[3] = '{1'b0, 7'h00, 8'h33, 8'h00, 1'b1, 8'h00};
    vecs[4] = '{1'b0, 7'h55, 8'h0F, 8'hC3, 1'b1, 8'hC3};
    order_exp[0] = 7'h7F; order_exp[1] = 7'h34; order_exp[2] = 7'h12;
    order_exp[3] = 7'h01; order_exp[4] = 7'h55;

    // Reset state
    doReset();
    checkOutput("reset level", 32'(level), 0);
    checkOutput("reset cmd_ready", 32'(cmd_ready), 1);
    checkOutput("reset busy", 32'(busy), 0);
    checkOutput("reset newd", 32'(newd), 0);
    checkOutput("reset wr", 32'(wr), 0);
    checkOutput("reset addr", 32'(addr), 0);
    checkOutput("reset din", 32'(din), 0);
    checkOutput("reset rsp_valid", 32'(rsp_valid), 0);
    checkOutput("reset rsp_data", 32'(rsp_data), 0);
    checkOutput("reset rsp_addr", 32'(rsp_addr), 0);
    checkOutput("reset timeout_err", 32'(timeout_err), 0);

    // Single-transaction vector table
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, vecs[i].wr, vecs[i].addr, vecs[i].data);
      tick();
      applyStimulus(1'b0, 1'b0, 7'h0, 8'h0);
      checkOutput($sformatf("vec%0d level after push", i), 32'(level), 1);
      checkOutput($sformatf("vec%0d busy before issue", i), 32'(busy), 0);
      tick();
      checkOutput($sformatf("vec%0d newd latency", i), 32'(newd), 1);
      checkOutput($sformatf("vec%0d wr", i), 32'(wr), 32'(vecs[i].wr));
      checkOutput($sformatf("vec%0d addr", i), 32'(addr), 32'(vecs[i].addr));
      if (vecs[i].wr) checkOutput($sformatf("vec%0d din", i), 32'(din), 32'(vecs[i].data));
      checkOutput($sformatf("vec%0d busy issue", i), 32'(busy), 1);
      tick();
      checkOutput($sformatf("vec%0d newd one cycle", i), 32'(newd), 0);
      tick();
      tick();
      checkOutput($sformatf("vec%0d addr stable", i), 32'(addr), 32'(vecs[i].addr));
      done = 1'b1;
      datard = vecs[i].rd;
      tick();
      done = 1'b0;
      datard = 8'hEE;
      checkOutput($sformatf("vec%0d addr after done", i), 32'(addr), 32'(vecs[i].addr));
      checkOutput($sformatf("vec%0d rsp_valid early", i), 32'(rsp_valid), 0);
      checkOutput($sformatf("vec%0d busy after done", i), 32'(busy), vecs[i].wr ? 0 : 1);
      tick();
      checkOutput($sformatf("vec%0d rsp_valid", i), 32'(rsp_valid), 32'(vecs[i].exp_rsp));
      if (vecs[i].exp_rsp) begin
        checkOutput($sformatf("vec%0d rsp_data", i), 32'(rsp_data), 32'(vecs[i].exp_rsp_data));
        checkOutput($sformatf("vec%0d rsp_addr", i), 32'(rsp_addr), 32'(vecs[i].addr));
      end
      checkOutput($sformatf("vec%0d busy idle", i), 32'(busy), 0);
      tick();
      tick();
      checkOutput($sformatf("vec%0d rsp_valid held", i), 32'(rsp_valid), 32'(vecs[i].exp_rsp));
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      checkOutput($sformatf("vec%0d rsp_valid cleared", i), 32'(rsp_valid), 0);
    end

    // Full FIFO and ordering while the core is stalled on a prior write
    applyStimulus(1'b1, 1'b1, 7'h60, 8'h00);
    tick();
    applyStimulus(1'b0, 1'b0, 7'h0, 8'h0);
    waitNewd("full dummy", got_a, got_w, got_d);
    checkOutput("full dummy addr", 32'(got_a), 32'h60);
    tick();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b1, order_exp[i], 8'(i));
      tick();
    end
    applyStimulus(1'b0, 1'b0, 7'h0, 8'h0);
    checkOutput("full level", 32'(level), 4);
    checkOutput("full cmd_ready", 32'(cmd_ready), 0);
    applyStimulus(1'b1, 1'b1, 7'h55, 8'h99);
    tick();
    applyStimulus(1'b0, 1'b0, 7'h0, 8'h0);
    checkOutput("full fifth held level", 32'(level), 4);
    done = 1'b1;
    tick();
    done = 1'b0;
    for (int k = 0; k < 5; k++) begin
      waitNewd("order", got_a, got_w, got_d);
      checkOutput($sformatf("order addr%0d", k), 32'(got_a), 32'(order_exp[k]));
      finishTxn(8'h00);
      if (k == 0) begin
        checkOutput("order level after first pop", 32'(level), 3);
        checkOutput("order cmd_ready reopens", 32'(cmd_ready), 1);
        applyStimulus(1'b1, 1'b1, 7'h55, 8'h99);
        tick();
        applyStimulus(1'b0, 1'b0, 7'h0, 8'h0);
      end
    end
    checkOutput("order drained level", 32'(level), 0);

    // Response backpressure holds back a second read
    applyStimulus(1'b1, 1'b0, 7'h21, 8'h00);
    tick();
    applyStimulus(1'b1, 1'b0, 7'h22, 8'h00);
    tick();
    applyStimulus(1'b0, 1'b0, 7'h0, 8'h0);
    waitNewd("bp first", got_a, got_w, got_d);
    checkOutput("bp first addr", 32'(got_a), 32'h21);
    finishTxn(8'h11);
    tick();
    checkOutput("bp rsp_valid", 32'(rsp_valid), 1);
    checkOutput("bp rsp_data", 32'(rsp_data), 32'h11);
    checkOutput("bp rsp_addr", 32'(rsp_addr), 32'h21);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (newd) seen = 1'b1;
    end
    checkOutput("bp second withheld", 32'(seen), 0);
    checkOutput("bp level", 32'(level), 1);
    checkOutput("bp rsp still held", 32'(rsp_valid), 1);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    waitNewd("bp second", got_a, got_w, got_d);
    checkOutput("bp second addr", 32'(got_a), 32'h22);
    finishTxn(8'h99);
    tick();
    checkOutput("bp second rsp_data", 32'(rsp_data), 32'h99);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    // Reset while waiting on the core discards everything
    applyStimulus(1'b1, 1'b0, 7'h40, 8'h00);
    tick();
    applyStimulus(1'b1, 1'b1, 7'h41, 8'h00);
    tick();
    applyStimulus(1'b0, 1'b0, 7'h0, 8'h0);
    waitNewd("rst", got_a, got_w, got_d);
    tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    checkOutput("rst level", 32'(level), 0);
    checkOutput("rst busy", 32'(busy), 0);
    checkOutput("rst cmd_ready", 32'(cmd_ready), 1);
    done = 1'b1;
    datard = 8'h77;
    tick();
    done = 1'b0;
    tick();
    tick();
    checkOutput("rst late done rsp_valid", 32'(rsp_valid), 0);
    checkOutput("rst late done busy", 32'(busy), 0);
    checkOutput("rst late done newd", 32'(newd), 0);
    checkOutput("rst addr cleared", 32'(addr), 0);

`ifdef I2C_SEQ_TIMEOUT_EN
    // Watchdog aborts a stalled transaction and the queue carries on
    applyStimulus(1'b1, 1'b1, 7'h0A, 8'h01);
    tick();
    applyStimulus(1'b1, 1'b1, 7'h0B, 8'h02);
    tick();
    applyStimulus(1'b0, 1'b0, 7'h0, 8'h0);
    waitNewd("tmo first", got_a, got_w, got_d);
    for (int i = 1; i <= TMO; i++) tick();
    checkOutput("tmo err before limit", 32'(timeout_err), 0);
    checkOutput("tmo busy before limit", 32'(busy), 1);
    tick();
    checkOutput("tmo err set", 32'(timeout_err), 1);
    checkOutput("tmo busy after abort", 32'(busy), 0);
    checkOutput("tmo no response", 32'(rsp_valid), 0);
    tick();
    checkOutput("tmo next newd", 32'(newd), 1);
    checkOutput("tmo next addr", 32'(addr), 32'h0B);
    finishTxn(8'h00);
    checkOutput("tmo err sticky", 32'(timeout_err), 1);
    checkOutput("tmo busy done", 32'(busy), 0);
`else
    // Without the watchdog a stalled transaction waits indefinitely
    applyStimulus(1'b1, 1'b1, 7'h0A, 8'h01);
    tick();
    applyStimulus(1'b0, 1'b0, 7'h0, 8'h0);
    waitNewd("stall", got_a, got_w, got_d);
    for (int i = 0; i < 3 * TMO; i++) tick();
    checkOutput("stall busy", 32'(busy), 1);
    checkOutput("stall timeout_err", 32'(timeout_err), 0);
    done = 1'b1;
    tick();
    done = 1'b0;
    checkOutput("stall released", 32'(busy), 0);
`endif

    // Randomized traffic against the reference model
    doReset();
    mq.delete();
    inflight = 1'b0; resp_phase = 1'b0; exp_rv = 1'b0; pop_pending = 1'b0;
    since = 0; delay = 1; exp_rd = '0; exp_ra = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      applyStimulus($urandom_range(0, 2) != 0, 1'($urandom), 7'($urandom), 8'($urandom));
      in_wait = inflight && (since >= 1);
      if (in_wait) done = (since >= delay);
      else done = ($urandom_range(0, 5) == 0);
      datard = 8'($urandom);
      rsp_ready = ($urandom_range(0, 3) == 0);
      pre_idle = !inflight && !resp_phase;
      will_issue = pre_idle && (mq.size() > 0) && (mq[0].wr || !exp_rv);
      accepted = cmd_valid && (mq.size() < DEPTH);
      tick();
      if (pop_pending) begin
        void'(mq.pop_front());
        pop_pending = 1'b0;
      end
      if (accepted) mq.push_back('{cmd_wr, cmd_addr, cmd_data});
      if (exp_rv && rsp_ready) exp_rv = 1'b0;
      if (resp_phase) begin
        exp_rv = 1'b1;
        resp_phase = 1'b0;
      end
      if (in_wait && done) begin
        inflight = 1'b0;
        if (!cur.wr) begin
          resp_phase = 1'b1;
          exp_rd = datard;
          exp_ra = cur.addr;
        end
      end else if (inflight) begin
        since++;
      end
      if (will_issue) begin
        inflight = 1'b1;
        since = 0;
        cur = mq[0];
        pop_pending = 1'b1;
        delay = $urandom_range(1, 6);
      end
      checkOutput("rnd newd", 32'(newd), 32'(will_issue));
      if (will_issue) begin
        checkOutput("rnd wr", 32'(wr), 32'(cur.wr));
        checkOutput("rnd addr", 32'(addr), 32'(cur.addr));
        if (cur.wr) checkOutput("rnd din", 32'(din), 32'(cur.data));
      end
      checkOutput("rnd level", 32'(level), 32'(mq.size()));
      checkOutput("rnd cmd_ready", 32'(cmd_ready), 32'(mq.size() < DEPTH));
      checkOutput("rnd busy", 32'(busy), 32'(inflight || resp_phase));
      checkOutput("rnd rsp_valid", 32'(rsp_valid), 32'(exp_rv));
      if (exp_rv) begin
        checkOutput("rnd rsp_data", 32'(rsp_data), 32'(exp_rd));
        checkOutput("rnd rsp_addr", 32'(rsp_addr), 32'(exp_ra));
      end
    end
    applyStimulus(1'b0, 1'b0, 7'h0, 8'h0);
    done = 1'b0;
    rsp_ready = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
